// File: rtl/pattern_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_fsm_pkg
//  Description : Shared types and helpers for the serial pattern generator.
//                - state_t   : FSM state encoding (IDLE, SEND, DONE)
//                - calc_half : clk cycles per half period of hzClk
//  Revision    : 1.0 - initial release
// ============================================================================
package pattern_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of clk cycles hzClk spends in each level.
    function automatic int calc_half(input int clk_freq, input int out_freq);
        return clk_freq / (2 * out_freq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hz_divider.sv
`default_nettype none
// ============================================================================
//  Module      : hz_divider
//  Description : Divides clk down to a 50% duty square wave (hzClk) and
//                emits a one-cycle tick on the cycle whose edge raises hzClk.
//  Ports       : clk   - system clock
//                reset - asynchronous, active-high reset
//                hzClk - divided square wave, straight from a flop
//                tick  - combinational, high on the cycle before hzClk rises
//  Revision    : 1.0 - initial release
// ============================================================================
module hz_divider
    import pattern_fsm_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int OUT_FREQ = 1
) (
    input  logic clk,
    input  logic reset,
    output logic hzClk,
    output logic tick
);

    localparam int HALF  = calc_half(CLK_FREQ, OUT_FREQ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HALF - 1);

    generate
        if (HALF < 1) begin : g_half_check
            $error("hz_divider: CLK_FREQ/(2*OUT_FREQ) must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_hzclk;
    logic             w_wrap;

    assign w_wrap = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_hzclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_hzclk <= ~r_hzclk;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Only the wrap that takes hzClk low->high advances the FSM, so the
    // serial bit changes on the same edge as the hzClk rising edge.
    assign tick  = w_wrap && !r_hzclk;
    assign hzClk = r_hzclk;

endmodule
`default_nettype wire

// File: rtl/pattern_fsm_top.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_fsm_top
//  Description : Slow serial pattern generator. Shifts PATTERN out MSB first,
//                one bit per hzClk period, while start is seen high on a tick.
//                A single 0 gap period follows every complete pattern.
//  Ports       : clk   - system clock
//                reset - asynchronous, active-high reset
//                start - level transmit request, sampled only on tick
//                out   - registered serial pattern bit
//                hzClk - registered divided square wave, 50% duty
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_fsm_top
    import pattern_fsm_pkg::*;
#(
    parameter int               CLK_FREQ = 50_000_000,
    parameter int               OUT_FREQ = 1,
    parameter int               PAT_W    = 8,
    parameter logic [PAT_W-1:0] PATTERN  = 8'hB2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic out,
    output logic hzClk
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] C_IDX_MSB = IDX_W'(PAT_W - 1);

    generate
        if (PAT_W < 1) begin : g_patw_check
            $error("pattern_fsm_top: PAT_W must be at least 1");
        end
    endgenerate

    logic             w_tick;
    logic [IDX_W-1:0] w_idx_dec;
    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_out;

    hz_divider #(
        .CLK_FREQ (CLK_FREQ),
        .OUT_FREQ (OUT_FREQ)
    ) u_hz_divider (
        .clk   (clk),
        .reset (reset),
        .hzClk (hzClk),
        .tick  (w_tick)
    );

    assign w_idx_dec = r_idx - IDX_W'(1);

    // r_idx is the index of the bit currently on out; the next bit is
    // loaded on the following tick, so each bit lasts one hzClk period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_out   <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= SEND;
                        r_idx   <= C_IDX_MSB;
                        r_out   <= PATTERN[PAT_W-1];
                    end else begin
                        r_state <= IDLE;
                        r_out   <= 1'b0;
                    end
                end
                SEND: begin
                    // start is ignored here: a pattern always completes.
                    if (r_idx == '0) begin
                        r_state <= DONE;
                        r_out   <= 1'b0;
                    end else begin
                        r_idx   <= w_idx_dec;
                        r_out   <= PATTERN[w_idx_dec];
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_pattern_fsm_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_fsm_top
//  Description : Self-checking bench for pattern_fsm_top (HALF = 5,
//                PATTERN = 8'hB2). Table-driven pattern sequences, directed
//                corner cases and randomized start/reset against a queue
//                based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_fsm_top;

    localparam int         CLK_FREQ  = 10;
    localparam int         OUT_FREQ  = 1;
    localparam int         HALF      = CLK_FREQ / (2 * OUT_FREQ);
    localparam int         PAT_W     = 8;
    localparam logic [7:0] C_PATTERN = 8'hB2;

    logic clk;
    logic reset;
    logic start;
    logic out;
    logic hz_clk;

    pattern_fsm_top #(
        .CLK_FREQ (CLK_FREQ),
        .OUT_FREQ (OUT_FREQ),
        .PAT_W    (PAT_W),
        .PATTERN  (C_PATTERN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .out   (out),
        .hzClk (hz_clk)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge count since reset plus a queue of pending bits.
    int   m_n;
    logic m_out;
    logic m_hz;
    logic q[$];

    typedef struct {
        logic start;
        logic exp_out;
    } rise_vec_t;

    rise_vec_t tbl[3][10];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_n   = 0;
        m_out = 1'b0;
        m_hz  = 1'b0;
        q.delete();
    endtask

    // One clk edge: advance the model, then compare #1 after the edge.
    task automatic step();
        bit is_tick;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            m_n++;
            is_tick = ((m_n % (2 * HALF)) == HALF);
            if ((m_n % HALF) == 0) m_hz = ~m_hz;
            if (is_tick) begin
                if (q.size() > 0) begin
                    m_out = q.pop_front();
                end else if (start) begin
                    for (int i = PAT_W - 1; i >= 0; i--) q.push_back(C_PATTERN[i]);
                    q.push_back(1'b0);
                    m_out = q.pop_front();
                end else begin
                    m_out = 1'b0;
                end
            end
        end
        #1;
        check("out", out, m_out);
        check("hzClk", hz_clk, m_hz);
    endtask

    // Called 1 time unit after an edge (or at start of sim); asserts reset
    // mid-cycle and checks the outputs clear before any clock edge.
    task automatic do_reset(input int ncyc);
        #4;
        reset = 1'b1;
        #1;
        check("async_rst_out", out, 1'b0);
        check("async_rst_hz", hz_clk, 1'b0);
        model_clear();
        repeat (ncyc) step();
        reset = 1'b0;
    endtask

    task automatic run_table(input int t);
        do_reset(2);
        start = tbl[t][0].start;
        repeat (HALF - 1) step();
        for (int i = 0; i < 10; i++) begin
            start = tbl[t][i].start;
            step();
            check($sformatf("tbl%0d_rise%0d_out", t, i + 1), out, tbl[t][i].exp_out);
            check($sformatf("tbl%0d_rise%0d_hz", t, i + 1), hz_clk, 1'b1);
            repeat (2 * HALF - 1) step();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int ones;
        logic [7:0] exp_a;

        // Table 0: start held -> pattern, gap, restart.
        exp_a = C_PATTERN;
        for (int i = 0; i < 8; i++) tbl[0][i] = '{1'b1, exp_a[7-i]};
        tbl[0][8] = '{1'b1, 1'b0};
        tbl[0][9] = '{1'b1, 1'b1};
        // Table 1: start dropped after bit 4 -> pattern completes, gap, idle.
        for (int i = 0; i < 8; i++) tbl[1][i] = '{(i < 4) ? 1'b1 : 1'b0, exp_a[7-i]};
        tbl[1][8] = '{1'b0, 1'b0};
        tbl[1][9] = '{1'b0, 1'b0};
        // Table 2: start held across a single tick only.
        for (int i = 0; i < 8; i++) tbl[2][i] = '{(i == 0) ? 1'b1 : 1'b0, exp_a[7-i]};
        tbl[2][8] = '{1'b0, 1'b0};
        tbl[2][9] = '{1'b0, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        model_clear();
        #2;

        // Reset held 3 cycles; first hzClk rise on 5th edge, period 10.
        do_reset(3);
        k = 0;
        while (hz_clk !== 1'b1 && k < 12) begin
            step();
            k++;
        end
        check_int("first_rise_edge", k, HALF);
        k = 0;
        while (hz_clk !== 1'b0 && k < 12) begin
            step();
            k++;
        end
        check_int("high_time", k, HALF);
        while (hz_clk !== 1'b1 && k < 24) begin
            step();
            k++;
        end
        check_int("period", k, 2 * HALF);

        // Idle divider with start low.
        ones = 0;
        repeat (40) begin
            step();
            if (out === 1'b1) ones++;
        end
        check_int("idle_out_ones", ones, 0);

        for (int t = 0; t < 3; t++) run_table(t);

        // One-cycle start pulse away from a tick is ignored.
        do_reset(2);
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        ones = 0;
        repeat (30) begin
            step();
            if (out === 1'b1) ones++;
        end
        check_int("pulse_ignored_ones", ones, 0);

        // Reset asserted mid-SEND after the 3rd bit.
        do_reset(2);
        start = 1'b1;
        repeat (HALF + 4 * HALF) step();
        check("pre_rst_bit3", out, 1'b1);
        step();
        step();
        do_reset(2);
        repeat (HALF - 1) step();
        step();
        check("restart_msb", out, 1'b1);
        repeat (3 * 2 * HALF) step();

        // Randomized start levels with occasional resets.
        for (int n = 0; n < 120; n++) begin
            start = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
            repeat ($urandom_range(1, 25)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_fsm_top.md
Name: pattern_fsm_top

Overview:
- Top-level block for a slow serial pattern generator.
- A divider derives a low-frequency square wave, hzClk, from the system clock.
- An FSM in the clk domain, advanced by a one-cycle tick per hzClk period, shifts a fixed PAT_W-bit pattern out MSB-first on out.
- Controlled by the start level.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- OUT_FREQ, 1: hzClk frequency in Hz.
- PAT_W, 8: pattern width in bits (>=1).
- PATTERN, 8'hB2: bit pattern, transmitted MSB first.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level request to transmit; sampled only on tick.
- out  output  1  serial pattern bit, registered.
- hzClk  output  1  divided square wave, registered, 50% duty.

Behaviour:
- HALF = CLK_FREQ/(2*OUT_FREQ). Elaboration error if HALF < 1.
- Divider:
  - cnt counts 0..HALF-1.
  - When cnt==HALF-1: cnt<=0 and hzClk<=~hzClk. Otherwise cnt<=cnt+1.
  - Period = 2*HALF clk cycles.
- tick = (cnt==HALF-1) && (hzClk==0), combinational. FSM updates on the same edge where hzClk rises, so out changes coincident with the hzClk rising edge.
- Reset value of every register: cnt=0, hzClk=0, state=IDLE, idx=0, out=0. Reset takes effect immediately, whether asserted mid-sequence or mid-period. Reset dominates all other inputs.
- FSM states: IDLE, SEND, DONE. All transitions occur only on a tick cycle; between ticks the state holds.
  - IDLE: out=0. On tick with start=1: go to SEND, idx<=PAT_W-1, out<=PATTERN[PAT_W-1]. On tick with start=0: stay.
  - SEND: on tick, if idx==0: go to DONE, out<=0. Otherwise idx<=idx-1, out<=PATTERN[idx-1].
  - DONE: out=0. On tick with start=1: go to SEND and restart from the MSB as in IDLE. Otherwise go to IDLE.
- Each pattern bit is held for exactly one hzClk period.
- Held start gives continuous repetition: PAT_W bit periods followed by one 0 gap period.
- start deasserted during SEND does not abort; the sequence completes.
- A start pulse that does not overlap a tick cycle is ignored.
- No other outputs. out and hzClk are glitch-free, coming straight from flops.

Decomposition:
- Package pattern_fsm_pkg holds:
  - typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  - localparam helper for the HALF computation.
- Sub-module hz_divider:
  - Parameters CLK_FREQ, OUT_FREQ.
  - Ports clk, reset, hzClk, tick.
- The FSM and output register live in pattern_fsm_top.

Test Plan:
All scenarios use CLK_FREQ=10, OUT_FREQ=1 (HALF=5), PAT_W=8, PATTERN=8'hB2, 20 ns clk.
1. Reset: hold reset=1 for 3 cycles -> out=0, hzClk=0 throughout. After release, the first hzClk rise occurs at the 5th clk edge; hzClk then toggles every 5 cycles with period 10.
2. Idle divider: start=0 for 40 cycles -> hzClk toggles normally; out stays 0.
3. Continuous: start=1 held from reset release -> out over successive hzClk rises = 1,0,1,1,0,0,1,0. The 9th rise gives out=0 (DONE). The 10th rise gives out=1, restarting the pattern.
4. Start filtering:
   - A one-cycle start pulse not on a tick cycle -> out stays 0.
   - start held across one tick, then dropped -> one full 8-bit pattern, then out=0 and the FSM returns to IDLE.
5. Reset mid-SEND: assert reset after the 3rd bit -> out=0, hzClk=0 asynchronously, before the next clk edge. After release with start=1, the pattern restarts from the MSB (1).
6. Start dropped mid-SEND after bit 4 -> the remaining bits 0,0,1,0 are still sent, then one 0 (DONE), then IDLE with out=0.
